// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver driven by an external baud strobe.
// The line is sampled only on baud_tick. With OVERSAMPLE > 1 the start bit
// is re-checked at its midpoint, so later samples land mid-bit. With
// OVERSAMPLE = 1 every tick samples one bit directly.
// data_out only changes when a frame ends with a valid stop bit.
module uart_rx #(
    parameter int OVERSAMPLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       baud_tick,
    output logic       rx_done,
    output logic [7:0] data_out
);

    // Half a bit period, in ticks. This is where the start bit is re-checked.
    localparam int HALF = OVERSAMPLE / 2;
    localparam int CW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE + 1) : 1;

    // Counter values on the tick that completes a full or half bit period.
    localparam logic [CW-1:0] OS_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((HALF > 0) ? HALF - 1 : 0);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_t;

    state_t          ps;
    logic [CW-1:0]   tick_counter;
    logic [2:0]      bit_index;
    logic [7:0]      shift_reg;

    // Receive state machine. rx_done and data_out are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps           <= IDLE;
            tick_counter <= '0;
            bit_index    <= '0;
            shift_reg    <= '0;
            rx_done      <= 1'b0;
            data_out     <= 8'h00;
        end else begin
            rx_done <= 1'b0;
            case (ps)
                IDLE: begin
                    // A low line is ignored unless it is seen on a tick.
                    if (baud_tick && !rx) begin
                        ps           <= START;
                        tick_counter <= '0;
                    end
                end

                START: begin
                    if (HALF == 0) begin
                        // There is no midpoint to re-check at one tick per bit.
                        ps           <= DATA;
                        tick_counter <= '0;
                        bit_index    <= '0;
                    end else if (baud_tick) begin
                        if (tick_counter == HALF_LAST) begin
                            tick_counter <= '0;
                            bit_index    <= '0;
                            // A line that is high again at the midpoint was a glitch.
                            ps           <= rx ? IDLE : DATA;
                        end else begin
                            tick_counter <= tick_counter + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (baud_tick) begin
                        if (tick_counter == OS_LAST) begin
                            tick_counter         <= '0;
                            shift_reg[bit_index] <= rx;
                            if (bit_index == 3'd7) begin
                                bit_index <= '0;
                                ps        <= STOP;
                            end else begin
                                bit_index <= bit_index + 1'b1;
                            end
                        end else begin
                            tick_counter <= tick_counter + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (baud_tick) begin
                        if (tick_counter == OS_LAST) begin
                            tick_counter <= '0;
                            ps           <= IDLE;
                            // A low stop bit is a framing error. The byte is dropped.
                            if (rx) begin
                                data_out <= shift_reg;
                                rx_done  <= 1'b1;
                            end
                        end else begin
                            tick_counter <= tick_counter + 1'b1;
                        end
                    end
                end

                default: begin
                    ps           <= IDLE;
                    tick_counter <= '0;
                    bit_index    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against two receivers,
// one with OVERSAMPLE=1 and one with OVERSAMPLE=4.
// Expected bytes, pulse counts and latency come from a frame-level model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx1 = 1'b1, tick1 = 1'b0, done1;
    logic       rx4 = 1'b1, tick4 = 1'b0, done4;
    logic [7:0] data1, data4;

    uart_rx #(.OVERSAMPLE(1)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .baud_tick(tick1),
        .rx_done(done1), .data_out(data1)
    );
    uart_rx #(.OVERSAMPLE(4)) dut4 (
        .clk(clk), .rst(rst), .rx(rx4), .baud_tick(tick4),
        .rx_done(done4), .data_out(data4)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    int n_done1 = 0, n_done4 = 0, dbl1 = 0, dbl4 = 0;
    int last_cyc1 = -1, last_cyc4 = -1, last_tick = 0;
    int stop_cyc1 = 0, stop_cyc4 = 0;
    logic prev1 = 1'b0, prev4 = 1'b0;

    // Frame-level reference model state.
    logic [7:0] exp1 = 8'h00, exp4 = 8'h00;
    int exp_n1 = 0, exp_n4 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe rx_done between edges: count pulses, note when, catch wide pulses.
    always @(negedge clk) begin
        if (done1) begin
            n_done1 = n_done1 + 1;
            last_cyc1 = cyc;
            if (prev1) dbl1 = dbl1 + 1;
        end
        if (done4) begin
            n_done4 = n_done4 + 1;
            last_cyc4 = cyc;
            if (prev4) dbl4 = dbl4 + 1;
        end
        prev1 = done1;
        prev4 = done4;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One baud tick for the 1x receiver, then idle out the rest of a 16-clk period.
    task automatic tick_1();
        @(negedge clk) tick1 = 1'b1;
        @(negedge clk) tick1 = 1'b0;
        last_tick = cyc;
        repeat (14) @(negedge clk);
    endtask

    // One baud tick for the 4x receiver, one pulse per 4 clk.
    task automatic tick_4();
        @(negedge clk) tick4 = 1'b1;
        @(negedge clk) tick4 = 1'b0;
        last_tick = cyc;
        repeat (2) @(negedge clk);
    endtask

    task automatic send1(input logic [7:0] b, input logic stopb);
        rx1 = 1'b0; tick_1();
        for (int i = 0; i < 8; i++) begin
            rx1 = b[i]; tick_1();
        end
        rx1 = stopb;
        @(negedge clk) tick1 = 1'b1;
        @(negedge clk) tick1 = 1'b0;
        stop_cyc1 = cyc;
        rx1 = 1'b1;
        repeat (14) @(negedge clk);
        if (stopb) begin
            exp1 = b;
            exp_n1++;
        end
    endtask

    task automatic send4(input logic [7:0] b, input logic stopb);
        rx4 = 1'b0;
        repeat (4) tick_4();
        for (int i = 0; i < 8; i++) begin
            rx4 = b[i];
            repeat (4) tick_4();
        end
        rx4 = stopb;
        repeat (3) tick_4();
        stop_cyc4 = last_tick;
        rx4 = 1'b1;
        tick_4();
        if (stopb) begin
            exp4 = b;
            exp_n4++;
        end
    endtask

    task automatic check1(input string tag, input logic stopb);
        check({tag, "_data"}, data1, exp1);
        check({tag, "_count"}, n_done1, exp_n1);
        if (stopb) check({tag, "_latency"}, last_cyc1, stop_cyc1);
    endtask

    task automatic check4(input string tag, input logic stopb);
        check({tag, "_data"}, data4, exp4);
        check({tag, "_count"}, n_done4, exp_n4);
        if (stopb) check({tag, "_latency"}, last_cyc4, stop_cyc4);
    endtask

    initial begin
        logic [7:0] b;
        logic       s;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_ps", dut1.ps, 4'b0001);
        check("reset_done", done1, 1'b0);
        check("reset_data", data1, 8'h00);
        check("reset_data4", data4, 8'h00);
        rst = 1'b0;

        // Idle line with free-running ticks.
        repeat (20) tick_1();
        check("idle_count", n_done1, 0);
        check("idle_ps", dut1.ps, 4'b0001);

        // Single frame, then a framing error that must leave data_out alone.
        send1(8'hA5, 1'b1);
        check1("frame_a5", 1'b1);
        send1(8'h12, 1'b0);
        check1("framing_err", 1'b0);
        check("framing_ps", dut1.ps, 4'b0001);

        // Back-to-back frames with no idle gap.
        send1(8'h3C, 1'b1);
        check1("b2b_3c", 1'b1);
        send1(8'hFF, 1'b1);
        check1("b2b_ff", 1'b1);

        // Asynchronous reset while bit 4 is on the line.
        rx1 = 1'b0; tick_1();
        for (int i = 0; i < 5; i++) begin
            rx1 = i[0]; tick_1();
        end
        #3 rst = 1'b1;
        #1;
        check("midrst_ps", dut1.ps, 4'b0001);
        check("midrst_data", data1, 8'h00);
        check("midrst_done", done1, 1'b0);
        exp1 = 8'h00;
        @(negedge clk) rst = 1'b0;
        rx1 = 1'b1;
        repeat (2) tick_1();
        send1(8'h5A, 1'b1);
        check1("after_rst_5a", 1'b1);

        // Random frames at one tick per bit, mostly with good stop bits.
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            send1(b, s);
            check1("rand1", s);
        end

        // 4x oversampling: start glitch rejected, then frames.
        rx4 = 1'b0; tick_4();
        rx4 = 1'b1;
        repeat (8) tick_4();
        check("glitch4_count", n_done4, 0);
        check("glitch4_ps", dut4.ps, 4'b0001);
        send4(8'hC3, 1'b1);
        check4("os4_c3", 1'b1);
        send4(8'h0F, 1'b0);
        check4("os4_framing", 1'b0);
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            send4(b, s);
            check4("rand4", s);
        end

        check("pulse_width1", dbl1, 0);
        check("pulse_width4", dbl4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
